demux4_buf: RTL and testbench

- Registered 1-to-4 demultiplexer with a valid/ready handshake on every port. It is the distribution-side counterpart of the mux family.
- One input word plus a 2-bit select is steered into one of four single-entry output holding buffers. Each buffer is drained independently by its consumer.
- Used in the multi-cycle CPU to fan a shared result bus out to separate sinks (register-file write, memory write data, PC, debug tap) without combinational fan-out hazards.

---
 rtl/demux4_buf.sv | 90 +++++++++
 tb/tb_demux4_buf.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 demultiplexer.
// - One input word is steered by s into one of four single-entry holding buffers.
// - Each buffer is drained independently by its own consumer.
// - in_ready passes through a same-cycle drain, so one word per cycle can flow.
module demux4_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3,
    output logic [2:0]       occ
);

    logic [3:0]       v_q;
    logic [3:0]       v_d;
    logic [WIDTH-1:0] y_q [4];
    logic [WIDTH-1:0] y_d [4];
    logic [2:0]       occ_q;
    logic [2:0]       occ_d;
    logic [3:0]       rdy;
    logic             accept;

    assign rdy = {r3, r2, r1, r0};

    // Ready when the selected buffer is empty or is being drained this cycle
    always_comb begin
        in_ready = !v_q[s] | rdy[s];
    end

    // Per-buffer next state: accept (incl. reload) beats drain beats hold;
    // occupancy is the popcount of the next valid flags so it can never wrap
    always_comb begin
        accept = in_valid & in_ready;
        occ_d  = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            y_d[n] = y_q[n];
            v_d[n] = v_q[n];
            if (accept && (s == n[1:0])) begin
                y_d[n] = d;
                v_d[n] = 1'b1;
            end else if (v_q[n] && rdy[n]) begin
                v_d[n] = 1'b0;
            end
            occ_d = occ_d + {2'b00, v_d[n]};
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                y_q[n] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int unsigned n = 0; n < 4; n++) begin
                y_q[n] <= y_d[n];
            end
        end
    end

    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];
    assign v0  = v_q[0];
    assign v1  = v_q[1];
    assign v2  = v_q[2];
    assign v3  = v_q[3];
    assign occ = occ_q;

endmodule

// File: tb/tb_demux4_buf.sv
// Testbench for demux4_buf: scoreboard of per-channel expected words,
// directed scenarios followed by randomized traffic.
module tb_demux4_buf;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
    logic [2:0]       occ;

    demux4_buf #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .d(d), .s(s),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each channel holds at most one word; a queue per channel
    logic [WIDTH-1:0] expq [4][$];
    int  n_total = 0;
    int  n_pass  = 0;
    bit  mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [WIDTH-1:0] get_y(input int n);
        case (n)
            0: return y0;
            1: return y1;
            2: return y2;
            default: return y3;
        endcase
    endfunction

    function automatic logic get_v(input int n);
        case (n)
            0: return v0;
            1: return v1;
            2: return v2;
            default: return v3;
        endcase
    endfunction

    function automatic logic get_r(input int n);
        case (n)
            0: return r0;
            1: return r1;
            2: return r2;
            default: return r3;
        endcase
    endfunction

    function automatic int total_words();
        int t = 0;
        for (int n = 0; n < 4; n++) t += expq[n].size();
        return t;
    endfunction

    // Monitor: inputs are settled mid-low-phase; compare DUT against the model,
    // then retire any word the model says a consumer takes at the next edge
    always begin
        @(negedge clk);
        #2;
        if (mon_en && rstn) begin
            chk("occ", 32'(occ), 32'(total_words()));
            chk("in_ready", 32'(in_ready),
                32'((expq[s].size() == 0) || get_r(int'(s))));
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("v%0d", n), 32'(get_v(n)), 32'(expq[n].size() != 0));
                if (expq[n].size() != 0) begin
                    chk($sformatf("y%0d", n), 32'(get_y(n)), 32'(expq[n][0]));
                    if (get_r(n)) void'(expq[n].pop_front());
                end
            end
        end
    end

    // Drive one cycle of stimulus; a word enters the model when its channel
    // has room after this cycle's drains (monitor has retired them by now)
    task automatic step(input bit iv, input logic [WIDTH-1:0] dd,
                        input logic [1:0] ss, input logic [3:0] rr);
        @(negedge clk);
        in_valid = iv;
        d        = dd;
        s        = ss;
        {r3, r2, r1, r0} = rr;
        #3;
        if (iv && expq[ss].size() == 0) expq[ss].push_back(dd);
    endtask

    task automatic check_all_clear(input string tag);
        chk({tag, "_occ"}, 32'(occ), 0);
        chk({tag, "_v"}, 32'({v3, v2, v1, v0}), 0);
        for (int n = 0; n < 4; n++) chk($sformatf("%s_y%0d", tag, n), 32'(get_y(n)), 0);
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        d = '0;
        s = '0;
        {r3, r2, r1, r0} = 4'b0000;

        // Reset / idle
        repeat (3) @(negedge clk);
        check_all_clear("rst");
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1;
            chk($sformatf("rst_ready_s%0d", i), 32'(in_ready), 1);
        end
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 8'h00, 2'd0, 4'b0000);

        // Basic steer into all four, then a blocked fifth word
        step(1'b1, 8'h11, 2'd0, 4'b0000);
        step(1'b1, 8'h22, 2'd1, 4'b0000);
        step(1'b1, 8'h33, 2'd2, 4'b0000);
        step(1'b1, 8'h44, 2'd3, 4'b0000);
        step(1'b1, 8'h55, 2'd2, 4'b0000);
        step(1'b1, 8'h55, 2'd2, 4'b0000);
        chk("full_occ", 32'(occ), 4);

        // Drain on channel 2 lets the held word in as a reload, then drain it
        step(1'b1, 8'h55, 2'd2, 4'b0100);
        step(1'b0, 8'h00, 2'd2, 4'b0100);
        step(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("after_drain_occ", 32'(occ), 3);

        // Empty everything, then stream eight words through channel 1
        step(1'b0, 8'h00, 2'd0, 4'b1111);
        for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i), 2'd1, 4'b0010);
        step(1'b0, 8'h00, 2'd1, 4'b0010);
        step(1'b0, 8'h00, 2'd1, 4'b0010);
        chk("stream_occ_end", 32'(occ), 0);

        // Mixed: two drains and an accept elsewhere in one cycle
        step(1'b1, 8'h01, 2'd0, 4'b0000);
        step(1'b1, 8'h03, 2'd3, 4'b0000);
        step(1'b1, 8'h77, 2'd1, 4'b1001);
        step(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("mixed_y1", 32'(y1), 32'h77);
        chk("mixed_occ", 32'(occ), 1);
        step(1'b1, 8'h5A, 2'd2, 4'b0000);
        step(1'b1, 8'hC3, 2'd0, 4'b0000);

        // Asynchronous reset pulse between edges with three buffers full
        @(negedge clk);
        mon_en   = 1'b0;
        in_valid = 1'b0;
        {r3, r2, r1, r0} = 4'b0000;
        chk("pre_rst_occ", 32'(occ), 3);
        #1 rstn = 1'b0;
        #1 check_all_clear("async");
        for (int n = 0; n < 4; n++) expq[n].delete();
        #1 rstn = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 8'h00, 2'd0, 4'b1111);
        step(1'b0, 8'h00, 2'd0, 4'b0000);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 4'($urandom));
        end
        step(1'b0, 8'h00, 2'd0, 4'b0000);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
